pipe_ctrl: RTL

Front-end pipeline controller for the vector encryption core. It sequences the fetch stage and the IF/ID pipe register, and drives the next-PC value and the enables for both. It also inserts bubbles toward execute. Decode-side events select the sequence: taken jump, end-of-program, memory access and load-use hazard.

---
 rtl/pipe_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Front-end pipeline controller: sequences fetch and IF/ID around jumps, end-of-program,
// memory stalls and load-use hazards. Control outputs are Mealy from the registered state.
module pipe_ctrl #(
  parameter int unsigned REGI_SIZE   = 16,
  parameter int unsigned JUMP_BITS   = 10,
  parameter int unsigned HAZ_CYCLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [REGI_SIZE-1:0] pc_i,
  input  logic                 jump_i,
  input  logic [JUMP_BITS-1:0] jump_addr_i,
  input  logic                 end_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ack_i,
  input  logic                 hazard_i,
  output logic [REGI_SIZE-1:0] pc_o,
  output logic                 pc_en_o,
  output logic                 ifid_en_o,
  output logic                 ifid_flush_o,
  output logic                 idex_bubble_o,
  output logic                 halted_o,
  output logic                 err_o,
  output logic [2:0]           state_o,
  output logic [15:0]          cyc_cnt_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StHaz   = 3'd2,
    StMemw  = 3'd3,
    StFlush = 3'd4,
    StHalt  = 3'd5
  } state_e;

  localparam logic [7:0] HazLast = 8'(HAZ_CYCLES);
  // Timeout fires on the MEM_TIMEOUT-th wait cycle, so the request cycle plus the
  // wait cycles hold the PC for at most MEM_TIMEOUT+1 cycles.
  localparam logic [7:0] MemLast = 8'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [15:0]          cyc_q, cyc_d;
  logic                 cyc_inc;
  logic                 restart;
  logic [REGI_SIZE-1:0] jump_pc;

  assign jump_pc = REGI_SIZE'(jump_addr_i);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    cyc_inc       = 1'b0;
    restart       = 1'b0;
    pc_o          = '0;
    pc_en_o       = 1'b0;
    ifid_en_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    halted_o      = 1'b0;

    case (state_q)
      StIdle: begin
        ifid_flush_o = 1'b1;
        if (start_i) begin
          state_d = StRun;
          restart = 1'b1;
        end
      end

      StRun: begin
        pc_o      = pc_i;
        pc_en_o   = 1'b1;
        ifid_en_o = 1'b1;
        cyc_inc   = 1'b1;
        if (end_i) begin
          pc_en_o      = 1'b0;
          ifid_flush_o = 1'b1;
          state_d      = StHalt;
        end else if (jump_i) begin
          pc_o         = jump_pc;
          ifid_flush_o = 1'b1;
          state_d      = StFlush;
        end else if (mem_req_i) begin
          pc_en_o   = 1'b0;
          ifid_en_o = 1'b0;
          cnt_d     = '0;
          state_d   = StMemw;
        end else if (hazard_i) begin
          pc_en_o       = 1'b0;
          ifid_en_o     = 1'b0;
          idex_bubble_o = 1'b1;
          cnt_d         = 8'd1;
          state_d       = StHaz;
        end
      end

      // Discards the instruction fetched from the old PC+1 while the target is fetched.
      StFlush: begin
        pc_o         = pc_i;
        pc_en_o      = 1'b1;
        ifid_flush_o = 1'b1;
        cyc_inc      = 1'b1;
        state_d      = StRun;
      end

      StHaz: begin
        idex_bubble_o = 1'b1;
        cyc_inc       = 1'b1;
        if (cnt_q == HazLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StMemw: begin
        idex_bubble_o = 1'b1;
        cyc_inc       = 1'b1;
        if (mem_ack_i) begin
          state_d = StRun;
        end else if (cnt_q == MemLast) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StHalt: begin
        ifid_flush_o = 1'b1;
        halted_o     = 1'b1;
        if (start_i) begin
          state_d = StRun;
          restart = 1'b1;
        end
      end

      // Corrupted state register: park in HALT and flag it.
      default: begin
        err_d   = 1'b1;
        state_d = StHalt;
      end
    endcase

    if (restart) begin
      err_d = 1'b0;
      cyc_d = '0;
    end else if (cyc_inc && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign state_o   = state_q;
  assign err_o     = err_q;
  assign cyc_cnt_o = cyc_q;

endmodule
